// File: rtl/rl_ram_nr1w_if.sv
// rl_ram_nr1w_if: write port, read ports and status of the multi-read-port RAM.
interface rl_ram_nr1w_if #(
  parameter int ABITS  = 10,
  parameter int DBITS  = 32,
  parameter int RPORTS = 2
);
  localparam int BEW = (DBITS + 7) / 8;
  logic                     ready;
  logic [ABITS-1:0]         waddr;
  logic [DBITS-1:0]         din;
  logic                     we;
  logic [BEW-1:0]           be;
  logic [RPORTS*ABITS-1:0]  raddr;
  logic [RPORTS-1:0]        re;
  logic [RPORTS*DBITS-1:0]  dout;
  logic [RPORTS-1:0]        dvalid;
  modport master (input ready, dout, dvalid, output waddr, din, we, be, raddr, re);
  modport slave  (output ready, dout, dvalid, input waddr, din, we, be, raddr, re);
endinterface

// File: rtl/rl_ram_nr1w.sv
// rl_ram_nr1w: 1-write / N-read RAM with byte-enable write-first bypass and clear sweep.
module rl_ram_nr1w #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  parameter int RPORTS = 2,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DBITS-1:0] CLEAR_VALUE = '0
) (
  input logic clk,
  input logic rst,
  rl_ram_nr1w_if.slave bus
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, next;
  logic [ABITS-1:0] cnt;
  logic [DBITS-1:0] mem [2**ABITS];
  logic [DBITS-1:0] wmask;
  logic wen;
  always_comb begin
    next = (state == CLEAR && &cnt) ? READY : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= (state == CLEAR) ? cnt + 1'b1 : '0;
    end
  end
  assign bus.ready = state == READY;
  assign wen = bus.ready & bus.we;
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DBITS; i++) wmask[i] = bus.be[i/8];
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= CLEAR_VALUE;
    else if (wen) mem[bus.waddr] <= (mem[bus.waddr] & ~wmask) | (bus.din & wmask);
  end
  for (genvar p = 0; p < RPORTS; p++) begin : g_rd
    logic [ABITS-1:0] ra;
    logic [DBITS-1:0] raw, din_q, wm_q, mrg;
    logic hit, rv, acc;
    assign ra = bus.raddr[p*ABITS +: ABITS];
    assign acc = bus.ready & bus.re[p];
    // bypass state is only captured on accepted reads so an idle port keeps its data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        raw <= '0;
        din_q <= '0;
        wm_q <= '0;
        hit <= 1'b0;
        rv <= 1'b0;
      end else begin
        rv <= acc;
        if (acc) begin
          raw <= mem[ra];
          din_q <= bus.din;
          wm_q <= wmask;
          hit <= wen && ra == bus.waddr;
        end
      end
    end
    assign mrg = hit ? (raw & ~wm_q) | (din_q & wm_q) : raw;
    if (OUT_REG != 0) begin : g_oreg
      logic [DBITS-1:0] dq;
      logic vq;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dq <= '0;
          vq <= 1'b0;
        end else begin
          vq <= rv;
          if (rv) dq <= mrg;
        end
      end
      assign bus.dout[p*DBITS +: DBITS] = dq;
      assign bus.dvalid[p] = vq;
    end else begin : g_comb
      assign bus.dout[p*DBITS +: DBITS] = mrg;
      assign bus.dvalid[p] = rv;
    end
  end
endmodule

// File: tb/tb_rl_ram_nr1w.sv
// tb_rl_ram_nr1w: scoreboard bench for two RAM configurations sharing clock and reset.
module tb_rl_ram_nr1w;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rl_ram_nr1w_if #(.ABITS(4), .DBITS(32), .RPORTS(3)) ia ();
  rl_ram_nr1w_if #(.ABITS(4), .DBITS(12), .RPORTS(2)) ib ();
  rl_ram_nr1w #(.ABITS(4), .DBITS(32), .RPORTS(3), .OUT_REG(0), .CLEAR_ON_RESET(1),
                .CLEAR_VALUE(32'h0)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  rl_ram_nr1w #(.ABITS(4), .DBITS(12), .RPORTS(2), .OUT_REG(1), .CLEAR_ON_RESET(1),
                .CLEAR_VALUE(12'h5A5)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  typedef struct {
    int d;
    int p;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  bit rdy = 0;
  logic [31:0] mdl_a [16];
  logic [11:0] mdl_b [16];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic sb_pop(input int d, input int p, input logic [31:0] got);
    int idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].d == d && sb[i].p == p) idx = i;
    if (idx < 0) chk($sformatf("spurious_%s_p%0d", d != 0 ? "b" : "a", p), 32'd1, 32'd0);
    else begin
      chk($sformatf("rd_%s_p%0d", d != 0 ? "b" : "a", p), got, sb[idx].v);
      sb.delete(idx);
    end
  endtask
  always @(negedge clk) begin
    for (int p = 0; p < 3; p++) if (ia.dvalid[p]) sb_pop(0, p, ia.dout[p*32 +: 32]);
    for (int p = 0; p < 2; p++) if (ib.dvalid[p]) sb_pop(1, p, {20'h0, ib.dout[p*12 +: 12]});
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op_a(input bit we, input logic [3:0] wa, input logic [31:0] d, input logic [3:0] be,
                      input logic [2:0] re, input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    logic [31:0] m;
    logic [3:0] ra [3];
    exp_t e;
    ra[0] = r0;
    ra[1] = r1;
    ra[2] = r2;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    ia.we = we; ia.waddr = wa; ia.din = d; ia.be = be; ia.re = re; ia.raddr = {r2, r1, r0};
    if (rdy) begin
      for (int p = 0; p < 3; p++) if (re[p]) begin
        e.d = 0;
        e.p = p;
        e.v = (we && ra[p] == wa) ? (mdl_a[ra[p]] & ~m) | (d & m) : mdl_a[ra[p]];
        sb.push_back(e);
      end
      if (we) mdl_a[wa] = (mdl_a[wa] & ~m) | (d & m);
    end
    tick();
    ia.we = 0; ia.re = '0;
  endtask
  task automatic op_b(input bit we, input logic [3:0] wa, input logic [11:0] d, input logic [1:0] be,
                      input logic [1:0] re, input logic [3:0] r0, input logic [3:0] r1);
    logic [11:0] m;
    logic [3:0] ra [2];
    exp_t e;
    ra[0] = r0;
    ra[1] = r1;
    m = {{4{be[1]}}, {8{be[0]}}};
    ib.we = we; ib.waddr = wa; ib.din = d; ib.be = be; ib.re = re; ib.raddr = {r1, r0};
    if (rdy) begin
      for (int p = 0; p < 2; p++) if (re[p]) begin
        e.d = 1;
        e.p = p;
        e.v = {20'h0, (we && ra[p] == wa) ? (mdl_b[ra[p]] & ~m) | (d & m) : mdl_b[ra[p]]};
        sb.push_back(e);
      end
      if (we) mdl_b[wa] = (mdl_b[wa] & ~m) | (d & m);
    end
    tick();
    ib.we = 0; ib.re = '0;
  endtask
  task automatic sweep(input string pre);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        chk({pre, "_rdy15_a"}, {31'b0, ia.ready}, 32'd0);
        chk({pre, "_rdy15_b"}, {31'b0, ib.ready}, 32'd0);
      end
      if (i == 16) begin
        chk({pre, "_rdy16_a"}, {31'b0, ia.ready}, 32'd1);
        chk({pre, "_rdy16_b"}, {31'b0, ib.ready}, 32'd1);
      end
      chk({pre, "_dv_a"}, {29'b0, ia.dvalid}, 32'd0);
      chk({pre, "_dv_b"}, {30'b0, ib.dvalid}, 32'd0);
    end
    ia.re = '0; ib.re = '0; ia.we = 0; ib.we = 0;
    rdy = 1;
    foreach (mdl_a[i]) mdl_a[i] = 32'h0;
    foreach (mdl_b[i]) mdl_b[i] = 12'h5A5;
  endtask
  task automatic read_all;
    for (int i = 0; i < 16; i++) begin
      op_a(0, 4'd0, 32'd0, 4'd0, 3'b111, 4'(i), 4'(i + 5), 4'(i + 9));
      op_b(0, 4'd0, 12'd0, 2'd0, 2'b11, 4'(i), 4'(15 - i));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    ia.we = 0; ia.waddr = '0; ia.din = '0; ia.be = '1; ia.re = '1; ia.raddr = '0;
    ib.we = 1; ib.waddr = '0; ib.din = '1; ib.be = '1; ib.re = '1; ib.raddr = '0;
    repeat (2) tick();
    chk("rst_rdy_a", {31'b0, ia.ready}, 32'd0);
    chk("rst_rdy_b", {31'b0, ib.ready}, 32'd0);
    chk("rst_dout_a", {31'b0, |ia.dout}, 32'd0);
    chk("rst_dv_b", {30'b0, ib.dvalid}, 32'd0);
    rst = 0;
    sweep("clr");
    read_all();
    op_a(1, 4'd5, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, 4'd0, 4'd0);
    op_a(1, 4'd5, 32'h11223344, 4'h5, 3'b000, 4'd0, 4'd0, 4'd0);
    op_a(0, 4'd0, 32'h0, 4'h0, 3'b001, 4'd5, 4'd0, 4'd0);
    op_a(1, 4'd3, 32'hAAAAAAAA, 4'hF, 3'b000, 4'd0, 4'd0, 4'd0);
    op_a(1, 4'd3, 32'h12345678, 4'h6, 3'b011, 4'd3, 4'd3, 4'd0);
    op_a(0, 4'd0, 32'h0, 4'h0, 3'b111, 4'd3, 4'd3, 4'd3);
    op_a(1, 4'd1, 32'h01010101, 4'hF, 3'b000, 4'd0, 4'd0, 4'd0);
    op_a(1, 4'd2, 32'h02020202, 4'hF, 3'b000, 4'd0, 4'd0, 4'd0);
    op_a(0, 4'd0, 32'h0, 4'h0, 3'b111, 4'd1, 4'd2, 4'd1);
    op_a(0, 4'd0, 32'h0, 4'h0, 3'b101, 4'd4, 4'd0, 4'd6);
    @(negedge clk);
    chk("hold_dout1", ia.dout[63:32], 32'h02020202);
    chk("hold_dv1", {31'b0, ia.dvalid[1]}, 32'd0);
    #1;
    op_a(1, 4'd9, 32'hCAFEF00D, 4'hF, 3'b000, 4'd0, 4'd0, 4'd0);
    op_a(1, 4'd9, 32'h0, 4'h0, 3'b111, 4'd9, 4'd9, 4'd9);
    op_b(1, 4'd2, 12'h000, 2'b11, 2'b00, 4'd0, 4'd0);
    op_b(1, 4'd2, 12'hFFF, 2'b10, 2'b00, 4'd0, 4'd0);
    op_b(0, 4'd0, 12'h000, 2'b00, 2'b01, 4'd2, 4'd0);
    op_b(1, 4'd7, 12'hABC, 2'b01, 2'b11, 4'd7, 4'd7);
    op_b(0, 4'd0, 12'h000, 2'b00, 2'b10, 4'd0, 4'd7);
    repeat (250) begin
      op_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)));
      op_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 12'($urandom), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end
    op_a(0, 4'd0, 32'h0, 4'h0, 3'b001, 4'd5, 4'd0, 4'd0);
    repeat (4) tick();
    chk("pre_rst_dout", ia.dout[31:0], 32'hDE22BE44);
    rst = 1;
    rdy = 0;
    ia.re = '1; ib.re = '1; ia.we = 1; ia.be = '1;
    #1;
    chk("async_dout_a", {31'b0, |ia.dout}, 32'd0);
    chk("async_rdy_a", {31'b0, ia.ready}, 32'd0);
    chk("async_rdy_b", {31'b0, ib.ready}, 32'd0);
    repeat (2) tick();
    rst = 0;
    repeat (7) tick();
    rst = 1;
    #1;
    chk("mid_rdy_a", {31'b0, ia.ready}, 32'd0);
    chk("mid_dout_b", {31'b0, |ib.dout}, 32'd0);
    repeat (2) tick();
    rst = 0;
    sweep("resweep");
    read_all();
    repeat (4) tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
